// File: rtl/video_geom_meter.sv
// Video geometry meter.
// Registers the raw core video by one cycle and, in parallel, measures active
// width/height and total line/frame size in pixel-CE units. A geometry is only
// published once it has repeated for STABLE_FRAMES consecutive frames, so the
// scaler never reacts to a single glitched or transitional frame.
module video_geom_meter #(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned CW            = 12
) (
  input  logic          CLK_VIDEO,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          hblank_in,
  input  logic          vblank_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [7:0]    r_in,
  input  logic [7:0]    g_in,
  input  logic [7:0]    b_in,
  output logic          ce_out,
  output logic          hblank_out,
  output logic          vblank_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [7:0]    r_out,
  output logic [7:0]    g_out,
  output logic [7:0]    b_out,
  output logic [CW-1:0] act_width,
  output logic [CW-1:0] act_height,
  output logic [CW-1:0] htotal,
  output logic [CW-1:0] vtotal,
  output logic          geom_valid,
  output logic          geom_change
);

  localparam logic [CW-1:0] CntMax    = {CW{1'b1}};
  localparam logic [CW-1:0] CntOne    = CW'(1);
  localparam logic [3:0]    StableThr = 4'(STABLE_FRAMES);
  localparam logic [3:0]    StableMax = 4'hF;

  // ---------------------------------------------------------------------------
  // Pass-through registers (every cycle, independent of measurement state)
  // ---------------------------------------------------------------------------
  logic       r_ce_out, r_hblank_out, r_vblank_out, r_hsync_out, r_vsync_out;
  logic [7:0] r_r_out, r_g_out, r_b_out;

  // Fixed one-cycle video delay, not gated by ce_pix.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      r_ce_out     <= 1'b0;
      r_hblank_out <= 1'b0;
      r_vblank_out <= 1'b0;
      r_hsync_out  <= 1'b0;
      r_vsync_out  <= 1'b0;
      r_r_out      <= 8'd0;
      r_g_out      <= 8'd0;
      r_b_out      <= 8'd0;
    end else begin
      r_ce_out     <= ce_pix;
      r_hblank_out <= hblank_in;
      r_vblank_out <= vblank_in;
      r_hsync_out  <= hsync_in;
      r_vsync_out  <= vsync_in;
      r_r_out      <= r_in;
      r_g_out      <= g_in;
      r_b_out      <= b_in;
    end
  end

  assign ce_out     = r_ce_out;
  assign hblank_out = r_hblank_out;
  assign vblank_out = r_vblank_out;
  assign hsync_out  = r_hsync_out;
  assign vsync_out  = r_vsync_out;
  assign r_out      = r_r_out;
  assign g_out      = r_g_out;
  assign b_out      = r_b_out;

  // ---------------------------------------------------------------------------
  // Per-frame counters (advance on ce_pix only)
  // ---------------------------------------------------------------------------
  logic          r_hb_prev, r_hs_prev, r_vs_prev;
  logic          r_armed;     // first vsync edge after reset seen
  logic          r_sat;       // some counter saturated in the current frame
  logic [CW-1:0] r_line_act, r_max_w, r_lines_act, r_htot, r_cur_htot, r_vtot;

  logic          w_active, w_hb_rise, w_hs_rise, w_vs_rise, w_sat_evt;
  logic [CW-1:0] w_line_act_d, w_max_w_d, w_lines_act_d, w_htot_d, w_cur_htot_d, w_vtot_d;
  logic [CW-1:0] w_vtot_close;

  // Edges are taken against the previous ce-qualified sample.
  assign w_active  = ce_pix & ~hblank_in & ~vblank_in;
  assign w_hb_rise = ce_pix & hblank_in & ~r_hb_prev;
  assign w_hs_rise = ce_pix & hsync_in & ~r_hs_prev;
  assign w_vs_rise = ce_pix & vsync_in & ~r_vs_prev;

  // Counter next-state; hsync action precedes the vsync frame close on the same ce.
  always_comb begin
    w_line_act_d  = r_line_act;
    w_max_w_d     = r_max_w;
    w_lines_act_d = r_lines_act;
    w_htot_d      = r_htot;
    w_cur_htot_d  = r_cur_htot;
    w_vtot_d      = r_vtot;
    w_vtot_close  = CntMax;
    w_sat_evt     = 1'b0;

    if (w_active) begin
      if (r_line_act == CntMax) w_sat_evt = 1'b1;
      else                      w_line_act_d = r_line_act + CntOne;
    end

    if (w_hb_rise) begin
      if (r_line_act > r_max_w) w_max_w_d = r_line_act;
      if (r_line_act != '0) begin
        if (r_lines_act == CntMax) w_sat_evt = 1'b1;
        else                       w_lines_act_d = r_lines_act + CntOne;
      end
      w_line_act_d = '0;
    end

    if (ce_pix) begin
      if (r_htot == CntMax) w_sat_evt = 1'b1;
      else                  w_htot_d = r_htot + CntOne;
    end

    if (w_hs_rise) begin
      w_cur_htot_d = (r_htot == CntMax) ? CntMax : r_htot + CntOne;
      w_htot_d     = '0;
      if (r_vtot == CntMax) w_sat_evt = 1'b1;
      else                  w_vtot_d = r_vtot + CntOne;
    end

    if (w_vs_rise) begin
      // +1 accounts for the line that begins on this edge.
      if (r_vtot == CntMax) w_sat_evt = 1'b1;
      else                  w_vtot_close = r_vtot + CntOne;
      w_max_w_d     = '0;
      w_lines_act_d = '0;
      w_vtot_d      = '0;
    end
  end

  // Counter and edge-history state.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      r_hb_prev   <= 1'b0;
      r_hs_prev   <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_armed     <= 1'b0;
      r_sat       <= 1'b0;
      r_line_act  <= '0;
      r_max_w     <= '0;
      r_lines_act <= '0;
      r_htot      <= '0;
      r_cur_htot  <= '0;
      r_vtot      <= '0;
    end else if (ce_pix) begin
      r_hb_prev   <= hblank_in;
      r_hs_prev   <= hsync_in;
      r_vs_prev   <= vsync_in;
      r_line_act  <= w_line_act_d;
      r_max_w     <= w_max_w_d;
      r_lines_act <= w_lines_act_d;
      r_htot      <= w_htot_d;
      r_cur_htot  <= w_cur_htot_d;
      r_vtot      <= w_vtot_d;
      if (w_vs_rise)      r_sat <= 1'b0;
      else if (w_sat_evt) r_sat <= 1'b1;
      if (w_vs_rise)      r_armed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame close: capture the measurement (partial frame before arming is dropped)
  // ---------------------------------------------------------------------------
  logic          r_check, r_meas_bad;
  logic [CW-1:0] r_meas_w, r_meas_h, r_meas_ht, r_meas_vt;

  // Snapshot the finished frame and request a stability check next cycle.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      r_check    <= 1'b0;
      r_meas_bad <= 1'b0;
      r_meas_w   <= '0;
      r_meas_h   <= '0;
      r_meas_ht  <= '0;
      r_meas_vt  <= '0;
    end else begin
      r_check <= w_vs_rise & r_armed;
      if (w_vs_rise && r_armed) begin
        r_meas_bad <= r_sat | w_sat_evt;
        r_meas_w   <= r_max_w;
        r_meas_h   <= r_lines_act;
        r_meas_ht  <= w_cur_htot_d;
        r_meas_vt  <= w_vtot_close;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stability tracking and publication
  // ---------------------------------------------------------------------------
  logic [3:0]      r_stable;
  logic [CW-1:0]   r_prev_w, r_prev_h, r_prev_ht, r_prev_vt;
  logic [CW-1:0]   r_act_width, r_act_height, r_htotal, r_vtotal;
  logic            r_geom_valid, r_geom_change;

  logic [4*CW-1:0] w_meas, w_prev, w_pub;
  logic            w_frame_bad, w_publish;
  logic [3:0]      w_stable_d;

  assign w_meas = {r_meas_w, r_meas_h, r_meas_ht, r_meas_vt};
  assign w_prev = {r_prev_w, r_prev_h, r_prev_ht, r_prev_vt};
  assign w_pub  = {r_act_width, r_act_height, r_htotal, r_vtotal};

  // Stable-count update and publish decision for the frame just closed.
  always_comb begin
    w_frame_bad = r_meas_bad | (r_meas_w == '0) | (r_meas_h == '0);
    w_stable_d  = r_stable;
    if (r_check) begin
      if (w_frame_bad)          w_stable_d = 4'd0;
      else if (w_meas == w_prev) w_stable_d = (r_stable == StableMax) ? StableMax
                                                                     : r_stable + 4'd1;
      else                      w_stable_d = 4'd1;
    end
    // An already-published identical geometry does not re-pulse.
    w_publish = r_check & ~w_frame_bad & (w_stable_d >= StableThr) &
                (~r_geom_valid | (w_meas != w_pub));
  end

  // History, published geometry and the one-cycle change pulse.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      r_stable      <= 4'd0;
      r_prev_w      <= '0;
      r_prev_h      <= '0;
      r_prev_ht     <= '0;
      r_prev_vt     <= '0;
      r_act_width   <= '0;
      r_act_height  <= '0;
      r_htotal      <= '0;
      r_vtotal      <= '0;
      r_geom_valid  <= 1'b0;
      r_geom_change <= 1'b0;
    end else begin
      r_geom_change <= w_publish;
      if (r_check) begin
        r_stable  <= w_stable_d;
        r_prev_w  <= r_meas_w;
        r_prev_h  <= r_meas_h;
        r_prev_ht <= r_meas_ht;
        r_prev_vt <= r_meas_vt;
      end
      if (w_publish) begin
        r_act_width  <= r_meas_w;
        r_act_height <= r_meas_h;
        r_htotal     <= r_meas_ht;
        r_vtotal     <= r_meas_vt;
        r_geom_valid <= 1'b1;
      end else if (r_check && w_frame_bad) begin
        // Only a bad frame withdraws validity; mismatches just hold old values.
        r_geom_valid <= 1'b0;
      end
    end
  end

  assign act_width   = r_act_width;
  assign act_height  = r_act_height;
  assign htotal      = r_htotal;
  assign vtotal      = r_vtotal;
  assign geom_valid  = r_geom_valid;
  assign geom_change = r_geom_change;

endmodule

// File: tb/tb_video_geom_meter.sv
// Directed bench for video_geom_meter using a scaled-down synthetic timing
// (32x20 total, 20x12 / 24x10 active) so whole frames stay cheap to simulate.
module tb_video_geom_meter;

  localparam int unsigned CW = 12;
  localparam int          XA = 2;   // first active pixel in a line
  localparam int          YA = 3;   // first active line in a frame
  localparam int          HT = 32;
  localparam int          VT = 20;

  logic          CLK_VIDEO = 1'b0;
  logic          reset     = 1'b1;
  logic          ce_pix    = 1'b0;
  logic          hblank_in = 1'b0;
  logic          vblank_in = 1'b0;
  logic          hsync_in  = 1'b0;
  logic          vsync_in  = 1'b0;
  logic [7:0]    r_in      = 8'd0;
  logic [7:0]    g_in      = 8'd0;
  logic [7:0]    b_in      = 8'd0;
  logic          ce_out, hblank_out, vblank_out, hsync_out, vsync_out;
  logic [7:0]    r_out, g_out, b_out;
  logic [CW-1:0] act_width, act_height, htotal, vtotal;
  logic          geom_valid, geom_change;

  video_geom_meter #(
    .STABLE_FRAMES (3),
    .CW            (CW)
  ) u_dut (
    .CLK_VIDEO   (CLK_VIDEO),
    .reset       (reset),
    .ce_pix      (ce_pix),
    .hblank_in   (hblank_in),
    .vblank_in   (vblank_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .ce_out      (ce_out),
    .hblank_out  (hblank_out),
    .vblank_out  (vblank_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .act_width   (act_width),
    .act_height  (act_height),
    .htotal      (htotal),
    .vtotal      (vtotal),
    .geom_valid  (geom_valid),
    .geom_change (geom_change)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  int n_tests     = 0;
  int n_fail      = 0;
  int cyc         = 0;
  int vs_edge_cyc = 0;
  int n_pulse     = 0;
  int pulse_lag   = -1;

  always @(posedge CLK_VIDEO) cyc <= cyc + 1;

  // Count geom_change pulses and their distance from the latest vsync edge.
  always @(negedge CLK_VIDEO) begin
    if (geom_change) begin
      n_pulse   <= n_pulse + 1;
      pulse_lag <= cyc - vs_edge_cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; outputs are looked at 1 ns after the edge.
  task automatic step(input logic ce, input logic hb, input logic vb, input logic hs,
                      input logic vs, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    ce_pix    = ce;
    hblank_in = hb;
    vblank_in = vb;
    hsync_in  = hs;
    vsync_in  = vs;
    r_in      = r;
    g_in      = g;
    b_in      = b;
    @(posedge CLK_VIDEO);
    #1;
  endtask

  // Lines y0..y1-1 of a frame (first line starting at x0). hsync and vsync rise
  // together at (0,0). In half mode every pixel is followed by a ce=0 cycle
  // carrying inverted junk that must not disturb the measurement.
  task automatic run_frame(input int w, input int h, input int y0, input int x0,
                           input int y1, input bit half);
    for (int y = y0; y < y1; y++) begin
      for (int x = (y == y0) ? x0 : 0; x < HT; x++) begin
        logic hb, vb, hs, vs;
        hb = !(x >= XA && x < XA + w);
        vb = !(y >= YA && y < YA + h);
        hs = (x < 2);
        vs = (y == 0);
        step(1'b1, hb, vb, hs, vs, 8'(x), 8'(y), 8'h11);
        if (x == 0 && y == 0) vs_edge_cyc = cyc;
        if (half) step(1'b0, ~hb, ~vb, ~hs, ~vs, 8'hEE, 8'hEE, 8'hEE);
      end
    end
  endtask

  task automatic frames(input int n, input int w, input int h);
    for (int i = 0; i < n; i++) run_frame(w, h, 0, 0, VT, 1'b0);
  endtask

  // Short 6-pixel lines with no vsync and no vblank: drives the line count past 4095.
  task automatic long_lines(input int n);
    for (int l = 0; l < n; l++) begin
      for (int x = 0; x < 6; x++) begin
        step(1'b1, !(x >= 2 && x < 4), 1'b0, (x < 2), 1'b0, 8'h22, 8'h22, 8'h22);
      end
    end
  endtask

  initial begin
    // Reset with non-zero inputs: everything must read 0.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    check_eq("rst_r_out", 32'(r_out), 32'd0);
    check_eq("rst_ce_out", 32'(ce_out), 32'd0);
    check_eq("rst_hsync_out", 32'(hsync_out), 32'd0);
    check_eq("rst_geom_valid", 32'(geom_valid), 32'd0);
    check_eq("rst_act_width", 32'(act_width), 32'd0);
    check_eq("rst_htotal", 32'(htotal), 32'd0);
    reset = 1'b0;

    // Pass-through latency, including a ce=0 cycle.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 8'h00);
    check_eq("pt_r_out", 32'(r_out), 32'hA5);
    check_eq("pt_ce_out", 32'(ce_out), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h3C, 8'h5A);
    check_eq("pt_ce_out0", 32'(ce_out), 32'd0);
    check_eq("pt_r_out0", 32'(r_out), 32'd0);
    check_eq("pt_g_out", 32'(g_out), 32'h3C);
    check_eq("pt_b_out", 32'(b_out), 32'h5A);
    check_eq("pt_blank_sync", 32'({hblank_out, vblank_out, hsync_out, vsync_out}), 32'hF);

    // First edge discarded + 3 identical frames before publish.
    frames(3, 20, 12);
    check_eq("pre_pub_valid", 32'(geom_valid), 32'd0);
    check_eq("pre_pub_pulses", 32'(n_pulse), 32'd0);
    frames(1, 20, 12);
    check_eq("pub_pulses", 32'(n_pulse), 32'd1);
    check_eq("pub_lag", 32'(pulse_lag), 32'd1);
    check_eq("pub_width", 32'(act_width), 32'd20);
    check_eq("pub_height", 32'(act_height), 32'd12);
    check_eq("pub_htotal", 32'(htotal), 32'd32);
    check_eq("vtotal_coinc", 32'(vtotal), 32'd20);
    check_eq("pub_valid", 32'(geom_valid), 32'd1);

    // Same timing for 10 more frames (two at half ce rate): no re-pulse.
    frames(2, 20, 12);
    run_frame(20, 12, 0, 0, VT, 1'b1);
    run_frame(20, 12, 0, 0, VT, 1'b1);
    frames(6, 20, 12);
    check_eq("steady_pulses", 32'(n_pulse), 32'd1);
    check_eq("steady_valid", 32'(geom_valid), 32'd1);
    check_eq("steady_width", 32'(act_width), 32'd20);
    check_eq("steady_htotal", 32'(htotal), 32'd32);

    // New geometry: old values held until the 3rd identical new frame closes.
    frames(3, 24, 10);
    check_eq("sw_hold_width", 32'(act_width), 32'd20);
    check_eq("sw_hold_height", 32'(act_height), 32'd12);
    check_eq("sw_hold_pulses", 32'(n_pulse), 32'd1);
    frames(1, 24, 10);
    check_eq("sw_pulses", 32'(n_pulse), 32'd2);
    check_eq("sw_lag", 32'(pulse_lag), 32'd1);
    check_eq("sw_width", 32'(act_width), 32'd24);
    check_eq("sw_height", 32'(act_height), 32'd10);
    check_eq("sw_vtotal", 32'(vtotal), 32'd20);

    // Alternating widths never stabilise; published values and valid hold.
    for (int i = 0; i < 3; i++) begin
      frames(1, 20, 10);
      frames(1, 24, 10);
    end
    check_eq("alt_pulses", 32'(n_pulse), 32'd2);
    check_eq("alt_valid", 32'(geom_valid), 32'd1);
    check_eq("alt_width", 32'(act_width), 32'd24);
    check_eq("alt_height", 32'(act_height), 32'd10);

    // Saturated frame: valid drops, values held; normal timing republishes.
    long_lines(4100);
    frames(1, 20, 12);
    check_eq("sat_valid", 32'(geom_valid), 32'd0);
    check_eq("sat_width_held", 32'(act_width), 32'd24);
    check_eq("sat_pulses", 32'(n_pulse), 32'd2);
    frames(2, 20, 12);
    check_eq("sat_recov_early", 32'(geom_valid), 32'd0);
    frames(1, 20, 12);
    check_eq("sat_recov_valid", 32'(geom_valid), 32'd1);
    check_eq("sat_recov_pulses", 32'(n_pulse), 32'd3);
    check_eq("sat_recov_width", 32'(act_width), 32'd20);
    check_eq("sat_recov_height", 32'(act_height), 32'd12);

    // Mid-frame reset on the first pixel of line 1. The remainder of this frame
    // measures exactly like a full one, so only arming keeps it out of the count.
    run_frame(20, 12, 0, 0, 1, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h5A, 8'h5A);
    check_eq("mr_r_out", 32'(r_out), 32'd0);
    check_eq("mr_ce_out", 32'(ce_out), 32'd0);
    check_eq("mr_valid", 32'(geom_valid), 32'd0);
    check_eq("mr_width", 32'(act_width), 32'd0);
    check_eq("mr_vtotal", 32'(vtotal), 32'd0);
    reset = 1'b0;
    run_frame(20, 12, 1, 1, VT, 1'b0);
    frames(3, 20, 12);
    check_eq("mr_partial_dropped", 32'(geom_valid), 32'd0);
    check_eq("mr_pulses_early", 32'(n_pulse), 32'd3);
    frames(1, 20, 12);
    check_eq("mr_repub_valid", 32'(geom_valid), 32'd1);
    check_eq("mr_repub_pulses", 32'(n_pulse), 32'd4);
    check_eq("mr_repub_lag", 32'(pulse_lag), 32'd1);
    check_eq("mr_repub_width", 32'(act_width), 32'd20);
    check_eq("mr_repub_vtotal", 32'(vtotal), 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
